// File: rtl/branch_resolve_ctrl_if.sv
// Branch-resolve / BTB-update bundle.
// slave  : branch_resolve_ctrl side (consumes EX results, drives flush/redirect/BTB update)
// master : EX stage + BTB side
interface branch_resolve_ctrl_if;
    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_phit;
    logic [29:0] ex_paddr;
    logic        up_ready;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        upEN;
    logic [29:0] tag;
    logic [29:0] br_a;
    logic        stall_req;

    modport slave (
        input  ex_valid, ex_taken, ex_pc, ex_target, ex_phit, ex_paddr, up_ready,
        output flush, redirect_en, redirect_pc, upEN, tag, br_a, stall_req
    );

    modport master (
        output ex_valid, ex_taken, ex_pc, ex_target, ex_phit, ex_paddr, up_ready,
        input  flush, redirect_en, redirect_pc, upEN, tag, br_a, stall_req
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: checks resolved branches against the fetch-time
// prediction, sequences flush/redirect on a mispredict and queues BTB updates.
// Optional macro BRC_STATS_EN adds saturating branch/mispredict/drop counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | classify ex_valid branches, enqueue BTB updates
// FLUSH  | squash wrong path for FLUSH_CYCLES cycles, ex_valid ignored
module branch_resolve_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    branch_resolve_ctrl_if.slave bus
`ifdef BRC_STATS_EN
    ,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts,
    output logic [15:0]          stat_drops
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          redirect_en_q;
    logic [31:0]   redirect_pc_q;

    logic [59:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        valid_run;
    logic        addr_match;
    logic        mispredict;
    logic        enq;
    logic        deq;
    logic        do_wr;
    logic        drop;
    logic        empty;
    logic        full;
    logic [31:0] redirect_next;
    logic [59:0] head;

    // Classify the resolved branch and decide redirect/enqueue
    always_comb begin
        valid_run     = bus.ex_valid && (state == S_RUN);
        addr_match    = (bus.ex_paddr == bus.ex_target[31:2]);
        mispredict    = valid_run && ((bus.ex_phit && !bus.ex_taken) ||
                                      (!bus.ex_phit && bus.ex_taken) ||
                                      (bus.ex_phit && bus.ex_taken && !addr_match));
        // A predicted-taken branch that falls through leaves the BTB alone:
        // there is no invalidate, so only taken misses are written back.
        enq           = valid_run && bus.ex_taken && (!bus.ex_phit || !addr_match);
        redirect_next = (bus.ex_phit && !bus.ex_taken) ? (bus.ex_pc + 32'd4) : bus.ex_target;
    end

    // FIFO status and write/drop qualification
    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        deq   = !empty && bus.up_ready;
        do_wr = enq && (!full || deq);
        drop  = enq && full && !deq;
        head  = mem[rd_ptr];
    end

    assign bus.flush       = (state == S_FLUSH);
    assign bus.redirect_en = redirect_en_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.upEN        = deq;
    assign bus.tag         = empty ? 30'd0 : head[59:30];
    assign bus.br_a        = empty ? 30'd0 : head[29:0];
    assign bus.stall_req   = full;

    // Flush sequencer: flush window timed by a down-counter to terminal count
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= S_RUN;
            cnt           <= '0;
            redirect_en_q <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            case (state)
                S_RUN: begin
                    redirect_en_q <= 1'b0;
                    if (mispredict) begin
                        state         <= S_FLUSH;
                        cnt           <= CW'(FLUSH_CYCLES - 1);
                        redirect_en_q <= 1'b1;
                        redirect_pc_q <= redirect_next;
                    end
                end
                S_FLUSH: begin
                    redirect_en_q <= 1'b0;
                    if (cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state         <= S_RUN;
                    redirect_en_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care while empty since outputs are masked
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= {bus.ex_pc[31:2], bus.ex_target[31:2]};
        end
    end

    // FIFO pointers and occupancy; full slot is reused on simultaneous enq+deq
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !deq) begin
                count <= count + 1'b1;
            end else if (deq && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef BRC_STATS_EN
    // Saturating event counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            stat_drops       <= '0;
        end else begin
            if (valid_run && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 1'b1;
            end
            if (drop && (stat_drops != '1)) begin
                stat_drops <= stat_drops + 1'b1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
